// File: rtl/cordic_step_unit_pkg.sv
// Shared CORDIC definitions: mode names, binary-angle atan table and gain constant.
package cordic_step_unit_pkg;

    localparam string MODE_ROTATION  = "rotation";
    localparam string MODE_VECTORING = "vectoring";

    typedef enum logic {
        ROTATION  = 1'b0,
        VECTORING = 1'b1
    } mode_e;

    // atan(2^-i) with a full turn mapped to 2^32
    localparam logic [31:0] ATAN_Q32 [16] = '{
        32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2E, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C
    };

    // Scaled atan(2^-n) for an aw-bit binary angle (full turn = 2^aw), rounded.
    function automatic logic [31:0] atan_table(input int aw, input int n);
        logic [31:0] v;
        v = (n < 16) ? ATAN_Q32[n] : (ATAN_Q32[15] >> (n - 15));
        if (aw >= 32) return v;
        return (v + (32'd1 << (31 - aw))) >> (32 - aw);
    endfunction

    // CORDIC gain K = 0.607252935 scaled by 2^(dw-1), for dw in 2..33.
    function automatic logic [31:0] gain_k(input int dw);
        return (32'h9B74EDA8 + (32'd1 << (32 - dw))) >> (33 - dw);
    endfunction

endpackage

// File: rtl/cordic_step_unit_sat.sv
// Signed saturator: clamps an IW-bit value into OW bits.
module sat #(
    parameter int IW = 17,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] val,
    output logic signed [OW-1:0] res
);

    if (IW < OW) begin : g_bad
        $fatal(1, "sat: IW must be >= OW");
        assign res = '0;
    end else if (IW == OW) begin : g_pass
        assign res = val;
    end else begin : g_clamp
        // In range exactly when the dropped bits all equal the new sign bit
        logic [IW-OW:0] hi;
        logic           in_range;
        assign hi       = val[IW-1:OW-1];
        assign in_range = (&hi) | ~(|hi);

        always_comb begin
            res = val[OW-1:0];
            if (!in_range)
                res = val[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/cordic_step_unit.sv
// One CORDIC shift-and-add micro-rotation (rotation or vectoring), optionally
// registered and optionally saturating x/y.
module cordic_step_unit
    import cordic_step_unit_pkg::*;
#(
    parameter int              DW     = 16,
    parameter int              AW     = 16,
    parameter int              SHIFT  = 0,
    parameter logic [AW-1:0]   ATAN   = '0,
    parameter string           MODE   = "rotation",
    parameter bit              REG_EN = 1'b1,
    parameter bit              SAT_EN = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic signed [AW-1:0] a_i,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic signed [AW-1:0] a_o
);

    if (MODE != MODE_ROTATION && MODE != MODE_VECTORING) begin : g_bad_mode
        $fatal(1, "cordic_step_unit: MODE must be rotation or vectoring");
    end
    if (SHIFT < 0 || SHIFT >= DW) begin : g_bad_shift
        $fatal(1, "cordic_step_unit: SHIFT out of range");
    end
    if (ATAN[AW-1]) begin : g_bad_atan
        $fatal(1, "cordic_step_unit: ATAN MSB must be 0");
    end

    localparam mode_e MD = (MODE == MODE_VECTORING) ? VECTORING : ROTATION;

    logic signed [DW-1:0] xs, ys;
    logic        [DW:0]   xe, ye, xse, yse;
    logic signed [DW:0]   xw, yw;
    logic signed [DW-1:0] xn, yn;
    logic signed [AW-1:0] an;
    logic                 d_neg, sub;

    assign xs = x_i >>> SHIFT;
    assign ys = y_i >>> SHIFT;

    assign xe  = {x_i[DW-1], x_i};
    assign ye  = {y_i[DW-1], y_i};
    assign xse = {xs[DW-1], xs};
    assign yse = {ys[DW-1], ys};

    assign d_neg = (MD == VECTORING) ? y_i[DW-1] : a_i[AW-1];
    // x and a subtract together: rotation with d=+1, vectoring with d=-1; y does the opposite
    assign sub = (MD == VECTORING) ? d_neg : ~d_neg;

    assign xw = sub ? xe - yse : xe + yse;
    assign yw = sub ? ye + xse : ye - xse;
    assign an = sub ? a_i - ATAN : a_i + ATAN;

    if (SAT_EN) begin : g_sat
        sat #(.IW(DW + 1), .OW(DW)) u_sat_x (.val(xw), .res(xn));
        sat #(.IW(DW + 1), .OW(DW)) u_sat_y (.val(yw), .res(yn));
    end else begin : g_wrap
        logic unused_guard;
        assign xn = xw[DW-1:0];
        assign yn = yw[DW-1:0];
        assign unused_guard = xw[DW] ^ yw[DW];
    end

    if (REG_EN) begin : g_reg
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                x_o <= '0;
                y_o <= '0;
                a_o <= '0;
            end else begin
                x_o <= xn;
                y_o <= yn;
                a_o <= an;
            end
        end
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clk_i ^ rst_i;
        assign x_o = xn;
        assign y_o = yn;
        assign a_o = an;
    end

endmodule

// File: tb/tb_cordic_step_unit.sv
// Bench for cordic_step_unit: directed table, reset sequences, sat checks and
// a randomized scoreboard against an integer model across several configurations.
module tb_cordic_step_unit;

    logic clk = 1'b0;
    logic rst;
    logic signed [15:0] x, y, a;
    logic signed [15:0] ox [7];
    logic signed [15:0] oy [7];
    logic signed [15:0] oa [7];
    logic signed [16:0] sv;
    logic signed [15:0] sr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int inst;
        int x;
        int y;
        int a;
    } exp_t;

    typedef struct {
        int inst;
        int x;
        int y;
        int a;
        int ex;
        int ey;
        int ea;
    } vec_t;

    exp_t q[$];
    localparam int NT = 13;
    vec_t tbl [NT];

    always #5 clk = ~clk;

    // Instances 0..5 registered, 6 combinational
    cordic_step_unit #(.DW(16), .AW(16), .SHIFT(0), .ATAN(16'd8192), .MODE("rotation"),
                       .REG_EN(1'b1), .SAT_EN(1'b0)) u_r0 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .a_i(a),
        .x_o(ox[0]), .y_o(oy[0]), .a_o(oa[0]));
    cordic_step_unit #(.DW(16), .AW(16), .SHIFT(1), .ATAN(16'd8192), .MODE("rotation"),
                       .REG_EN(1'b1), .SAT_EN(1'b0)) u_r1 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .a_i(a),
        .x_o(ox[1]), .y_o(oy[1]), .a_o(oa[1]));
    cordic_step_unit #(.DW(16), .AW(16), .SHIFT(2), .ATAN(16'd8192), .MODE("rotation"),
                       .REG_EN(1'b1), .SAT_EN(1'b0)) u_r2 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .a_i(a),
        .x_o(ox[2]), .y_o(oy[2]), .a_o(oa[2]));
    cordic_step_unit #(.DW(16), .AW(16), .SHIFT(1), .ATAN(16'd8192), .MODE("vectoring"),
                       .REG_EN(1'b1), .SAT_EN(1'b0)) u_v1 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .a_i(a),
        .x_o(ox[3]), .y_o(oy[3]), .a_o(oa[3]));
    cordic_step_unit #(.DW(16), .AW(16), .SHIFT(3), .ATAN(16'd8192), .MODE("vectoring"),
                       .REG_EN(1'b1), .SAT_EN(1'b0)) u_v3 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .a_i(a),
        .x_o(ox[4]), .y_o(oy[4]), .a_o(oa[4]));
    cordic_step_unit #(.DW(16), .AW(16), .SHIFT(0), .ATAN(16'd8192), .MODE("rotation"),
                       .REG_EN(1'b1), .SAT_EN(1'b1)) u_r0s (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .a_i(a),
        .x_o(ox[5]), .y_o(oy[5]), .a_o(oa[5]));
    cordic_step_unit #(.DW(16), .AW(16), .SHIFT(2), .ATAN(16'd8192), .MODE("rotation"),
                       .REG_EN(1'b0), .SAT_EN(1'b0)) u_c2 (
        .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .a_i(a),
        .x_o(ox[6]), .y_o(oy[6]), .a_o(oa[6]));

    sat #(.IW(17), .OW(16)) u_sat (.val(sv), .res(sr));

    function automatic bit cfg_vec(input int i);
        return (i == 3) || (i == 4);
    endfunction

    function automatic int cfg_sh(input int i);
        case (i)
            1, 3:    return 1;
            2, 6:    return 2;
            4:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int wrap16(input int v);
        int m;
        m = (v + 32768) % 65536;
        if (m < 0) m += 65536;
        return m - 32768;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic exp_t model(input int i, input int xv, input int yv, input int av);
        exp_t e;
        int xs, ys, d, nx, ny, na;
        xs = xv >>> cfg_sh(i);
        ys = yv >>> cfg_sh(i);
        if (cfg_vec(i)) begin
            d  = (yv >= 0) ? 1 : -1;
            nx = xv + d * ys;
            ny = yv - d * xs;
            na = av + d * 8192;
        end else begin
            d  = (av >= 0) ? 1 : -1;
            nx = xv - d * ys;
            ny = yv + d * xs;
            na = av - d * 8192;
        end
        e.inst = i;
        e.x = (i == 5) ? clamp16(nx) : wrap16(nx);
        e.y = (i == 5) ? clamp16(ny) : wrap16(ny);
        e.a = wrap16(na);
        return e;
    endfunction

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0d, want %0d", nm, inst, act, exp);
        end
    endtask

    task automatic drive(input int xv, input int yv, input int av);
        x = 16'(xv);
        y = 16'(yv);
        a = 16'(av);
    endtask

    task automatic push_all();
        for (int i = 0; i < 6; i++) q.push_back(model(i, int'(x), int'(y), int'(a)));
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("x", e.inst, int'(ox[e.inst]), e.x);
            chk("y", e.inst, int'(oy[e.inst]), e.y);
            chk("a", e.inst, int'(oa[e.inst]), e.a);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 6; i++) begin
            chk({nm, "_x"}, i, int'(ox[i]), 0);
            chk({nm, "_y"}, i, int'(oy[i]), 0);
            chk({nm, "_a"}, i, int'(oa[i]), 0);
        end
    endtask

    task automatic chk_sat(input int v, input int exp);
        sv = 17'(v);
        #1;
        chk("sat", 7, int'(sr), exp);
    endtask

    initial begin
        exp_t e;
        tbl[0]  = '{0, 1000, 0, 100, 1000, 1000, -8092};
        tbl[1]  = '{2, 1000, 400, -5, 1100, 150, 8187};
        tbl[2]  = '{3, 1000, 600, 0, 1300, 100, 8192};
        tbl[3]  = '{3, 1000, -600, 0, 1300, -100, -8192};
        tbl[4]  = '{1, -3, -3, 0, -1, -5, -8192};
        tbl[5]  = '{0, 30000, 30000, 1, 0, -5536, -8191};
        tbl[6]  = '{5, 30000, 30000, 1, 0, 32767, -8191};
        tbl[7]  = '{5, -30000, -30000, 1, 0, -32768, -8191};
        tbl[8]  = '{0, -30000, -30000, 1, 0, 5536, -8191};
        tbl[9]  = '{4, 800, 0, -32768, 800, -100, -24576};
        tbl[10] = '{4, 100, 5, 30000, 100, -7, -27344};
        tbl[11] = '{6, 1000, 400, -5, 1100, 150, 8187};
        tbl[12] = '{0, 0, 0, -32768, 0, 0, -24576};

        sv = '0;
        rst = 1'b1;
        drive(1234, -777, 555);
        @(posedge clk); #1;
        chk_zero("rst1");
        @(posedge clk); #1;
        chk_zero("rst2");

        // Release: the first edge captures the inputs already present
        @(negedge clk);
        rst = 1'b0;
        push_all();
        @(posedge clk); #1;
        drain();

        // Reset mid-stream discards the sample presented at that edge
        @(negedge clk);
        drive(-2000, 3000, -4000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        push_all();
        @(posedge clk); #1;
        drain();

        for (int k = 0; k < NT; k++) begin
            @(negedge clk);
            drive(tbl[k].x, tbl[k].y, tbl[k].a);
            if (tbl[k].inst == 6) begin
                #1;
                chk("tbl_x", 6, int'(ox[6]), tbl[k].ex);
                chk("tbl_y", 6, int'(oy[6]), tbl[k].ey);
                chk("tbl_a", 6, int'(oa[6]), tbl[k].ea);
            end else begin
                e.inst = tbl[k].inst;
                e.x = tbl[k].ex;
                e.y = tbl[k].ey;
                e.a = tbl[k].ea;
                q.push_back(e);
            end
            @(posedge clk); #1;
            drain();
        end

        chk_sat(40000, 32767);
        chk_sat(-40000, -32768);
        chk_sat(1234, 1234);
        chk_sat(-32768, -32768);
        chk_sat(32767, 32767);
        chk_sat(32768, 32767);
        chk_sat(-32769, -32768);
        chk_sat(65535, 32767);

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            drive(int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
            push_all();
            #1;
            e = model(6, int'(x), int'(y), int'(a));
            chk("rnd_x", 6, int'(ox[6]), e.x);
            chk("rnd_y", 6, int'(oy[6]), e.y);
            chk("rnd_a", 6, int'(oa[6]), e.a);
            @(posedge clk); #1;
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
